voice_allocator: RTL and testbench
==================================

// Module: voice_allocator
// PURPOSE
//   Schedules note events onto NUM_VOICES wavegen slots; owns each slot's Run and Incr.
//   Accepts one note-on/off event per handshake and scans voices serially.
//   Picks a voice, then updates the slot registers that drive the WaveGen instances.
//   Sits between the bus-side channel/event source and the wavegens generate loop.
// PARAMETERS
//   NUM_VOICES  2  voice slots; 2..16
//   NOTE_WIDTH  7  note number width
//   INCR_WIDTH  8  phase increment width, matches WaveGen Incr
//   AGE_WIDTH   8  per-voice age counter width, saturating
// PORTS
//   Clock        in   1                      system clock, rising edge
//   Reset        in   1                      asynchronous, active-low; clears all state
//   EventValid   in   1                      event present
//   EventReady   out  1                      allocator can accept an event
//   EventNoteOn  in   1                      1=note-on, 0=note-off
//   EventNote    in   NOTE_WIDTH             note number
//   EventIncr    in   INCR_WIDTH             phase increment; used by note-on only
//   VoiceRun     out  NUM_VOICES             per-voice Run to WaveGen
//   VoiceIncr    out  NUM_VOICES*INCR_WIDTH  per-voice Incr; voice v at [v*INCR_WIDTH +: INCR_WIDTH]
//   AllocValid   out  1                      one-cycle pulse at commit, when a voice changed
//   AllocVoice   out  clog2(NUM_VOICES)      voice updated at commit
//   Stolen       out  1                      one-cycle pulse, commit replaced an active voice
//   Dropped      out  1                      one-cycle pulse, note-on discarded (all voices busy)
// BEHAVIOUR
//   Reset values: VoiceRun=0, VoiceIncr=0, all notes/ages=0, EventReady=0 while Reset low.
//     AllocValid/AllocVoice/Stolen/Dropped reset to 0. FSM resets to IDLE.
//   Reset mid-operation: the latched event is discarded, no commit pulse. EventReady=1 the first cycle after release.
//   FSM states:
//     IDLE: EventReady=1. Accept when EventValid&&EventReady: latch the event, go to SCAN with idx=0.
//     SCAN: examine voice idx, one voice per cycle. Go to COMMIT after idx==NUM_VOICES-1.
//     COMMIT: apply the result, pulse the outputs, go to IDLE.
//   Latency: accept at cycle 0, commit at cycle NUM_VOICES+1, EventReady high again at cycle NUM_VOICES+2.
//   Note-on selection, highest priority first:
//     (1) active voice with the same note: retrigger it, no Stolen.
//     (2) lowest-index voice with Run=0.
//     (3) full: see CONFIGURATION.
//   Note-on commit: Run=1, note and Incr loaded, age of the chosen voice = 0.
//     Every other active voice: age+1, saturating at 2^AGE_WIDTH-1.
//   Note-off: lowest-index active voice with a matching note gets Run=0; its Incr is held; AllocValid pulses.
//     No match: no change and no pulse.
//   Exactly one of AllocValid or Dropped pulses per note-on. Stolen implies AllocValid.
//   EventValid may drop while not ready, with no effect. Event inputs are ignored outside IDLE.
// CONFIGURATION
//   VOICE_ALLOC_STEAL_EN defined: when full, steal the voice with the largest age.
//     Ties go to the lowest index. Stolen and AllocValid pulse. Dropped is tied to 0.
//   VOICE_ALLOC_STEAL_EN undefined: when full, the note-on is discarded.
//     Dropped pulses at commit, no AllocValid. Stolen is tied to 0.
// STRUCTURE
//   synth_pkg: alloc_state_t enum {IDLE,SCAN,COMMIT}, VOICE_IDX_W=$clog2(NUM_VOICES) helper, AGE_MAX constant.
//   Sub-module voice_slot: one per voice. It holds run/note/incr/age.
//     It takes load, stop and age_tick strobes from the allocator FSM.
//     Its outputs run, note, incr and age feed the scan comparator.
// TESTING (NUM_VOICES=2; steal = VOICE_ALLOC_STEAL_EN defined)
//   1. Reset low mid-SCAN: VoiceRun=00, EventReady=0. After release, EventReady=1 and no AllocValid pulse.
//   2. Note-on 60/incr 0x0F: AllocVoice=0 at cycle 3, VoiceRun=01, VoiceIncr[7:0]=0x0F, EventReady=1 at cycle 4.
//   3. Note-on 60, 64, then note-off 60: VoiceRun goes 01 -> 11 -> 10; the note-off reports AllocVoice=0.
//   4. Note-on 60 twice: the second pulses AllocVoice=0 with no Stolen; VoiceRun stays 01.
//   5. Steal, on 60, 64, 67: the third pulses Stolen with AllocVoice=0 (oldest voice); voice 0 note=67, Run=11.
//   6. No steal, same stimulus: the third pulses Dropped with no AllocValid; voices hold notes 60/64.
//   Also check: note-off 99 with no match gives no pulse; a held EventValid during SCAN is accepted once.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared types and helpers for the voice allocator.
//   alloc_state_t : allocator FSM states (IDLE -> SCAN -> COMMIT -> IDLE)
//   voice_idx_w() : width of a voice index for a given voice count
package synth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } alloc_state_t;

  function automatic int unsigned voice_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/voice_slot.sv
// One voice slot: holds run flag, note number, phase increment and a
// saturating age counter for a single wavegen instance.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   load_i         : start the voice (run=1, note/incr loaded, age cleared)
//   stop_i         : stop the voice (run=0, note/incr held)
//   age_tick_i     : age+1 if running, saturating at all-ones
//   note_i, incr_i : values loaded by load_i
//   run_o, note_o, incr_o, age_o : current slot contents
module voice_slot
  import synth_pkg::*;
#(
  parameter int unsigned NOTE_WIDTH = 7,
  parameter int unsigned INCR_WIDTH = 8,
  parameter int unsigned AGE_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic                  stop_i,
  input  logic                  age_tick_i,
  input  logic [NOTE_WIDTH-1:0] note_i,
  input  logic [INCR_WIDTH-1:0] incr_i,
  output logic                  run_o,
  output logic [NOTE_WIDTH-1:0] note_o,
  output logic [INCR_WIDTH-1:0] incr_o,
  output logic [AGE_WIDTH-1:0]  age_o
);

  localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

  logic                  run_q,  run_d;
  logic [NOTE_WIDTH-1:0] note_q, note_d;
  logic [INCR_WIDTH-1:0] incr_q, incr_d;
  logic [AGE_WIDTH-1:0]  age_q,  age_d;

  always_comb begin
    run_d  = run_q;
    note_d = note_q;
    incr_d = incr_q;
    age_d  = age_q;
    if (load_i) begin
      run_d  = 1'b1;
      note_d = note_i;
      incr_d = incr_i;
      age_d  = '0;
    end else begin
      if (stop_i) run_d = 1'b0;
      if (age_tick_i && run_q && (age_q != AGE_MAX)) age_d = age_q + AGE_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q  <= 1'b0;
      note_q <= '0;
      incr_q <= '0;
      age_q  <= '0;
    end else begin
      run_q  <= run_d;
      note_q <= note_d;
      incr_q <= incr_d;
      age_q  <= age_d;
    end
  end

  assign run_o  = run_q;
  assign note_o = note_q;
  assign incr_o = incr_q;
  assign age_o  = age_q;

endmodule

// File: rtl/voice_allocator.sv
// Schedules note-on/off events onto NUM_VOICES wavegen slots. One event is
// accepted per handshake in IDLE, voices are scanned one per cycle in SCAN,
// and the decision is applied in COMMIT (with one-cycle result pulses).
// Optional feature macro: VOICE_ALLOC_STEAL_EN -- when all voices are busy,
// steal the oldest voice instead of dropping the note-on.
// Ports:
//   Clock, Reset (async, active-low)
//   EventValid/EventReady handshake; EventNoteOn, EventNote, EventIncr payload
//   VoiceRun, VoiceIncr : per-voice wavegen controls
//   AllocValid, AllocVoice, Stolen, Dropped : commit-cycle result pulses
module voice_allocator
  import synth_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 2,
  parameter int unsigned NOTE_WIDTH = 7,
  parameter int unsigned INCR_WIDTH = 8,
  parameter int unsigned AGE_WIDTH  = 8,
  localparam int unsigned IDX_W     = voice_idx_w(NUM_VOICES)
) (
  input  logic                             Clock,
  input  logic                             Reset,
  input  logic                             EventValid,
  output logic                             EventReady,
  input  logic                             EventNoteOn,
  input  logic [NOTE_WIDTH-1:0]            EventNote,
  input  logic [INCR_WIDTH-1:0]            EventIncr,
  output logic [NUM_VOICES-1:0]            VoiceRun,
  output logic [NUM_VOICES*INCR_WIDTH-1:0] VoiceIncr,
  output logic                             AllocValid,
  output logic [IDX_W-1:0]                 AllocVoice,
  output logic                             Stolen,
  output logic                             Dropped
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  alloc_state_t          state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  ev_on_q, ev_on_d;
  logic [NOTE_WIDTH-1:0] ev_note_q, ev_note_d;
  logic [INCR_WIDTH-1:0] ev_incr_q, ev_incr_d;
  logic                  match_found_q, match_found_d;
  logic [IDX_W-1:0]      match_idx_q, match_idx_d;
  logic                  free_found_q, free_found_d;
  logic [IDX_W-1:0]      free_idx_q, free_idx_d;
  logic                  act_load_q, act_load_d;
  logic                  act_stop_q, act_stop_d;
  logic                  alloc_valid_q, alloc_valid_d;
  logic [IDX_W-1:0]      alloc_voice_q, alloc_voice_d;
`ifdef VOICE_ALLOC_STEAL_EN
  logic                  stolen_q, stolen_d;
  logic [IDX_W-1:0]      oldest_idx_q, oldest_idx_d;
  logic [AGE_WIDTH-1:0]  oldest_age_q, oldest_age_d;
  logic [AGE_WIDTH-1:0]  cur_age;
`else
  logic                  dropped_q, dropped_d;
`endif

  logic [NUM_VOICES-1:0]                 run_w;
  logic [NUM_VOICES-1:0][NOTE_WIDTH-1:0] note_w;
  logic [NUM_VOICES-1:0][AGE_WIDTH-1:0]  age_w;
  logic [NUM_VOICES-1:0]                 load_v, stop_v, tick_v;

  logic                  cur_run;
  logic [NOTE_WIDTH-1:0] cur_note;

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_slot
    // act_* are only set while in COMMIT, so they double as commit strobes.
    assign load_v[v] = act_load_q && (alloc_voice_q == IDX_W'(v));
    assign stop_v[v] = act_stop_q && (alloc_voice_q == IDX_W'(v));
    assign tick_v[v] = act_load_q && (alloc_voice_q != IDX_W'(v));

    voice_slot #(
      .NOTE_WIDTH(NOTE_WIDTH),
      .INCR_WIDTH(INCR_WIDTH),
      .AGE_WIDTH (AGE_WIDTH)
    ) u_slot (
      .clk_i     (Clock),
      .rst_ni    (Reset),
      .load_i    (load_v[v]),
      .stop_i    (stop_v[v]),
      .age_tick_i(tick_v[v]),
      .note_i    (ev_note_q),
      .incr_i    (ev_incr_q),
      .run_o     (run_w[v]),
      .note_o    (note_w[v]),
      .incr_o    (VoiceIncr[v*INCR_WIDTH +: INCR_WIDTH]),
      .age_o     (age_w[v])
    );
  end

  assign cur_run  = run_w[idx_q];
  assign cur_note = note_w[idx_q];
`ifdef VOICE_ALLOC_STEAL_EN
  assign cur_age  = age_w[idx_q];
`else
  logic unused_age;
  assign unused_age = ^age_w;
`endif

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    ev_on_d       = ev_on_q;
    ev_note_d     = ev_note_q;
    ev_incr_d     = ev_incr_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    act_load_d    = 1'b0;
    act_stop_d    = 1'b0;
    alloc_valid_d = 1'b0;
    alloc_voice_d = alloc_voice_q;
`ifdef VOICE_ALLOC_STEAL_EN
    stolen_d      = 1'b0;
    oldest_idx_d  = oldest_idx_q;
    oldest_age_d  = oldest_age_q;
`else
    dropped_d     = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (EventValid) begin
          ev_on_d       = EventNoteOn;
          ev_note_d     = EventNote;
          ev_incr_d     = EventIncr;
          idx_d         = '0;
          match_found_d = 1'b0;
          free_found_d  = 1'b0;
`ifdef VOICE_ALLOC_STEAL_EN
          oldest_idx_d  = '0;
          oldest_age_d  = '0;
`endif
          state_d       = SCAN;
        end
      end
      SCAN: begin
        if (!match_found_q && cur_run && (cur_note == ev_note_q)) begin
          match_found_d = 1'b1;
          match_idx_d   = idx_q;
        end
        if (!free_found_q && !cur_run) begin
          free_found_d = 1'b1;
          free_idx_d   = idx_q;
        end
`ifdef VOICE_ALLOC_STEAL_EN
        // Strict '>' keeps the lowest index on equal ages.
        if (cur_run && (cur_age > oldest_age_q)) begin
          oldest_idx_d = idx_q;
          oldest_age_d = cur_age;
        end
`endif
        idx_d = idx_q + IDX_W'(1);
        // Decision uses the _d values so the last voice scanned is included.
        if (idx_q == LAST_IDX) begin
          state_d = COMMIT;
          if (ev_on_q) begin
            if (match_found_d) begin
              act_load_d    = 1'b1;
              alloc_valid_d = 1'b1;
              alloc_voice_d = match_idx_d;
            end else if (free_found_d) begin
              act_load_d    = 1'b1;
              alloc_valid_d = 1'b1;
              alloc_voice_d = free_idx_d;
            end else begin
`ifdef VOICE_ALLOC_STEAL_EN
              act_load_d    = 1'b1;
              alloc_valid_d = 1'b1;
              stolen_d      = 1'b1;
              alloc_voice_d = oldest_idx_d;
`else
              dropped_d     = 1'b1;
`endif
            end
          end else if (match_found_d) begin
            act_stop_d    = 1'b1;
            alloc_valid_d = 1'b1;
            alloc_voice_d = match_idx_d;
          end
        end
      end
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      ev_on_q       <= 1'b0;
      ev_note_q     <= '0;
      ev_incr_q     <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      act_load_q    <= 1'b0;
      act_stop_q    <= 1'b0;
      alloc_valid_q <= 1'b0;
      alloc_voice_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      ev_on_q       <= ev_on_d;
      ev_note_q     <= ev_note_d;
      ev_incr_q     <= ev_incr_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      act_load_q    <= act_load_d;
      act_stop_q    <= act_stop_d;
      alloc_valid_q <= alloc_valid_d;
      alloc_voice_q <= alloc_voice_d;
    end
  end

`ifdef VOICE_ALLOC_STEAL_EN
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      stolen_q     <= 1'b0;
      oldest_idx_q <= '0;
      oldest_age_q <= '0;
    end else begin
      stolen_q     <= stolen_d;
      oldest_idx_q <= oldest_idx_d;
      oldest_age_q <= oldest_age_d;
    end
  end
  assign Stolen  = stolen_q;
  assign Dropped = 1'b0;
`else
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) dropped_q <= 1'b0;
    else        dropped_q <= dropped_d;
  end
  assign Stolen  = 1'b0;
  assign Dropped = dropped_q;
`endif

  // Gated with Reset so the handshake is closed while reset is held.
  assign EventReady = (state_q == IDLE) && Reset;
  assign VoiceRun   = run_w;
  assign AllocValid = alloc_valid_q;
  assign AllocVoice = alloc_voice_q;

endmodule

// File: tb/tb_voice_allocator.sv
module tb_voice_allocator;

  localparam int unsigned NV = 2;
`ifdef VOICE_ALLOC_STEAL_EN
  localparam bit STEAL = 1'b1;
`else
  localparam bit STEAL = 1'b0;
`endif

  logic            Clock = 1'b0;
  logic            Reset;
  logic            EventValid;
  logic            EventReady;
  logic            EventNoteOn;
  logic [6:0]      EventNote;
  logic [7:0]      EventIncr;
  logic [NV-1:0]   VoiceRun;
  logic [NV*8-1:0] VoiceIncr;
  logic            AllocValid;
  logic [0:0]      AllocVoice;
  logic            Stolen;
  logic            Dropped;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: plain per-voice arrays.
  bit m_run [NV];
  int m_note[NV];
  int m_incr[NV];
  int m_age [NV];

  voice_allocator #(
    .NUM_VOICES(NV),
    .NOTE_WIDTH(7),
    .INCR_WIDTH(8),
    .AGE_WIDTH (8)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .EventValid (EventValid),
    .EventReady (EventReady),
    .EventNoteOn(EventNoteOn),
    .EventNote  (EventNote),
    .EventIncr  (EventIncr),
    .VoiceRun   (VoiceRun),
    .VoiceIncr  (VoiceIncr),
    .AllocValid (AllocValid),
    .AllocVoice (AllocVoice),
    .Stolen     (Stolen),
    .Dropped    (Dropped)
  );

  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NV; i++) begin
      m_run[i] = 1'b0; m_note[i] = 0; m_incr[i] = 0; m_age[i] = 0;
    end
  endfunction

  function automatic logic [NV-1:0] exp_run();
    logic [NV-1:0] r;
    for (int i = 0; i < NV; i++) r[i] = m_run[i];
    return r;
  endfunction

  function automatic logic [NV*8-1:0] exp_incr();
    logic [NV*8-1:0] r;
    for (int i = 0; i < NV; i++) r[i*8 +: 8] = 8'(m_incr[i]);
    return r;
  endfunction

  // Applies one event to the model and returns the expected commit pulses.
  function automatic void model_event(input bit on, input int note, input int incr,
                                      output bit v, output int voice,
                                      output bit st, output bit dr);
    int pick;
    v = 0; voice = 0; st = 0; dr = 0; pick = -1;
    if (on) begin
      for (int i = 0; i < NV; i++)
        if (pick < 0 && m_run[i] && m_note[i] == note) pick = i;
      for (int i = 0; i < NV; i++)
        if (pick < 0 && !m_run[i]) pick = i;
      if (pick < 0) begin
        if (STEAL) begin
          int best;
          best = -1;
          for (int i = 0; i < NV; i++)
            if (best < 0 || m_age[i] > m_age[best]) best = i;
          pick = best;
          st = 1;
        end else begin
          dr = 1;
        end
      end
      if (pick >= 0) begin
        for (int i = 0; i < NV; i++)
          if (i != pick && m_run[i] && m_age[i] < 255) m_age[i]++;
        m_run[pick] = 1; m_note[pick] = note; m_incr[pick] = incr; m_age[pick] = 0;
        v = 1; voice = pick;
      end
    end else begin
      for (int i = 0; i < NV; i++)
        if (pick < 0 && m_run[i] && m_note[i] == note) pick = i;
      if (pick >= 0) begin
        m_run[pick] = 0;
        v = 1; voice = pick;
      end
    end
  endfunction

  task automatic wait_ready();
    int cnt;
    cnt = 0;
    while (!EventReady && cnt < 32) begin
      @(negedge Clock);
      cnt++;
    end
    if (!EventReady) check_eq("ready_timeout", 64'(EventReady), 64'(1));
  endtask

  task automatic send_event(input bit on, input int note, input int incr, input bit hold);
    bit ev; int ev_voice; bit est; bit edr;
    wait_ready();
    EventValid  = 1'b1;
    EventNoteOn = on;
    EventNote   = 7'(note);
    EventIncr   = 8'(incr);
    @(posedge Clock);
    model_event(on, note, incr, ev, ev_voice, est, edr);
    #1;
    if (!hold) EventValid = 1'b0;
    EventNoteOn = 1'($urandom); EventNote = 7'($urandom); EventIncr = 8'($urandom);
    for (int c = 1; c <= NV; c++) begin
      @(negedge Clock);
      check_eq("scan_ready", 64'(EventReady), 64'(0));
      check_eq("scan_pulse", 64'({AllocValid, Stolen, Dropped}), 64'(0));
      EventNoteOn = 1'($urandom); EventNote = 7'($urandom); EventIncr = 8'($urandom);
    end
    @(negedge Clock);
    EventValid = 1'b0;
    check_eq("commit_ready", 64'(EventReady), 64'(0));
    check_eq("commit_valid", 64'(AllocValid), 64'(ev));
    if (ev) check_eq("commit_voice", 64'(AllocVoice), 64'(ev_voice));
    check_eq("commit_stolen", 64'(Stolen), 64'(est));
    check_eq("commit_dropped", 64'(Dropped), 64'(edr));
    @(negedge Clock);
    check_eq("ready_after", 64'(EventReady), 64'(1));
    check_eq("idle_pulse", 64'({AllocValid, Stolen, Dropped}), 64'(0));
    check_eq("voice_run", 64'(VoiceRun), 64'(exp_run()));
    check_eq("voice_incr", 64'(VoiceIncr), 64'(exp_incr()));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b0; EventValid = 1'b0; EventNoteOn = 1'b0; EventNote = '0; EventIncr = '0;
    model_reset();
    repeat (2) @(negedge Clock);
    check_eq("rst_run", 64'(VoiceRun), 64'(0));
    check_eq("rst_incr", 64'(VoiceIncr), 64'(0));
    check_eq("rst_ready", 64'(EventReady), 64'(0));
    check_eq("rst_pulse", 64'({AllocValid, Stolen, Dropped}), 64'(0));
    check_eq("rst_voice", 64'(AllocVoice), 64'(0));
    Reset = 1'b1;
    #1;
    check_eq("rel_ready", 64'(EventReady), 64'(1));

    // Populate voices, then reset while an event is in SCAN.
    send_event(1'b1, 60, 8'h21, 1'b0);
    send_event(1'b1, 64, 8'h42, 1'b0);
    wait_ready();
    EventValid = 1'b1; EventNoteOn = 1'b0; EventNote = 7'd60;
    @(posedge Clock);
    #1 EventValid = 1'b0;
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    check_eq("midscan_run", 64'(VoiceRun), 64'(0));
    check_eq("midscan_ready", 64'(EventReady), 64'(0));
    model_reset();
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    check_eq("post_rst_ready", 64'(EventReady), 64'(1));
    for (int c = 0; c < 4; c++) begin
      @(negedge Clock);
      check_eq("post_rst_pulse", 64'(AllocValid), 64'(0));
    end

    // Directed note sequences.
    send_event(1'b1, 60, 8'h0F, 1'b0);
    check_eq("first_on_run", 64'(VoiceRun), 64'(2'b01));
    send_event(1'b1, 60, 8'h33, 1'b0);
    check_eq("retrig_run", 64'(VoiceRun), 64'(2'b01));
    send_event(1'b1, 64, 8'h44, 1'b0);
    check_eq("two_on_run", 64'(VoiceRun), 64'(2'b11));
    send_event(1'b0, 60, 0, 1'b0);
    check_eq("off60_run", 64'(VoiceRun), 64'(2'b10));
    send_event(1'b0, 64, 0, 1'b0);
    send_event(1'b1, 60, 8'h10, 1'b0);
    send_event(1'b1, 64, 8'h20, 1'b0);
    send_event(1'b1, 67, 8'h30, 1'b0);
    check_eq("full_run", 64'(VoiceRun), 64'(2'b11));
    check_eq("full_incr0", 64'(VoiceIncr[7:0]), STEAL ? 64'(8'h30) : 64'(8'h10));
    send_event(1'b0, 99, 0, 1'b0);
    send_event(1'b1, 62, 8'h55, 1'b1);
    repeat (2) begin
      @(negedge Clock);
      check_eq("held_once_ready", 64'(EventReady), 64'(1));
      check_eq("held_once_pulse", 64'(AllocValid), 64'(0));
    end

    // Randomized traffic over a small note range to force matches and fills.
    for (int n = 0; n < 200; n++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      repeat (gap) @(negedge Clock);
      send_event(($urandom_range(0, 99) < 60), 60 + int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
